prog_seqdet: RTL and testbench
==============================

PROG_SEQDET -- requirements
Module: prog_seqdet

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: longest detectable pattern in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port cfg_load, input, 1: load pattern, length and mode this cycle.
REQ-006 SHALL have port cfg_pattern, input, MAX_LEN: pattern bits; bit 0 is the most recently received bit.
REQ-007 SHALL have port cfg_len, input, $clog2(MAX_LEN+1): pattern length in bits.
REQ-008 SHALL have port cfg_overlap, input, 1: 1 = overlapping matches allowed; 0 = non-overlapping.
REQ-009 SHALL have port x_valid, input, 1: x carries a serial bit this cycle.
REQ-010 SHALL have port x, input, 1: serial data bit.
REQ-011 SHALL have port z, output, 1: single-cycle match pulse.
REQ-012 SHALL have port match_cnt, output, CNT_W: saturating count of matches.
REQ-013 SHALL have port cfg_err, output, 1: sticky flag; last load had an illegal length.
REQ-014 SHALL have port state, output, 2: current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states UNCFG=0, FILL=1, DETECT=2.
REQ-016 SHALL, on cfg_load with 2<=cfg_len<=MAX_LEN, from any state: register the pattern, length and mode; clear the history and fill counter; clear cfg_err; go to FILL.
REQ-017 SHALL, on cfg_load with cfg_len<2 or cfg_len>MAX_LEN: set cfg_err, go to UNCFG, and clear the history.
REQ-018 SHALL leave match_cnt unchanged on cfg_load.
REQ-019 SHALL give cfg_load priority over x_valid in the same cycle; that x bit is dropped.
REQ-020 SHALL, in UNCFG, ignore x_valid, and z SHALL stay 0.
REQ-021 SHALL, in FILL or DETECT with x_valid=1, shift x into bit 0 of a MAX_LEN history register, move older bits up one position, and increment the fill counter, which saturates at the active length.
REQ-022 SHALL leave history, fill counter and state unchanged when x_valid=0.
REQ-023 SHALL move from FILL to DETECT when the fill counter reaches the active length.
REQ-024 SHALL detect a match when the fill counter reaches the active length and the low len bits of the next history equal the low len bits of the pattern.
REQ-025 SHALL assert z for exactly one cycle after the matching edge, with a latency of 1 clock from the sampled bit.
REQ-026 SHALL increment match_cnt on each match and hold it at all-ones (saturate).
REQ-027 SHALL, on a match with overlap=1, keep the history and remain in DETECT.
REQ-028 SHALL, on a match with overlap=0, clear the fill counter and return to FILL, so no bit of a matched pattern is reused.
REQ-029 SHALL compare only the low len bits; bits above len in the pattern are ignored.

Reset
REQ-030 SHALL, while rst=0, immediately force state=UNCFG, z=0, match_cnt=0, cfg_err=0, history=0, fill counter=0, pattern=0, len=0 and overlap=0.
REQ-031 SHALL make reset asserted mid-sequence discard all partial history; detection resumes only after a new cfg_load.

Structure
REQ-032 SHALL keep the FSM state encoding and the length legality limits in the shared package prog_seqdet_pkg.
REQ-033 SHALL put the history shift register and fill counter in one sub-module, seq_shiftreg, parametrised by MAX_LEN.
REQ-034 SHALL keep the FSM, comparator and counter in prog_seqdet.

Verification
REQ-035 SHALL cover load pattern 3'b101 (len 3, overlap 1), then stream 1,0,1,0,1 -> z pulses after the 3rd and 5th bits; match_cnt=2.
REQ-036 SHALL cover the same stream with overlap 0 -> z pulses after the 3rd bit only; match_cnt=1.
REQ-037 SHALL cover load len 4, pattern 4'b0110, with x_valid gapped every other cycle -> exactly one z pulse, 1 cycle after the 4th valid bit.
REQ-038 SHALL cover load cfg_len=0 and then cfg_len=MAX_LEN+1 -> cfg_err=1 and state=UNCFG, with no z for any input; a legal load then clears cfg_err.
REQ-039 SHALL cover assertion of rst after 2 of 3 pattern bits, release, reload, then the 3rd bit -> no z; a full pattern then gives z.
REQ-040 SHALL cover CNT_W=2 with 5 matches -> match_cnt saturates at 3.

Source files
------------

// File: rtl/prog_seqdet_pkg.sv
// prog_seqdet_pkg
//   Shared definitions for the programmable serial sequence detector:
//   FSM state encoding, pattern-length legality limits and a helper that
//   checks a requested length against them.
package prog_seqdet_pkg;

   // Shortest pattern the detector accepts, and the largest MAX_LEN the
   // design is meant to be built with.
   localparam int MIN_LEN       = 2;
   localparam int MAX_LEN_LIMIT = 32;

   typedef enum logic [1:0] {
      UNCFG  = 2'd0,  // no legal configuration; serial input ignored
      FILL   = 2'd1,  // collecting bits until a full pattern is held
      DETECT = 2'd2   // every new bit completes a candidate window
   } state_t;

   // True when len is a usable pattern length for a detector built with
   // max_len history bits.
   function automatic logic len_legal(input int len, input int max_len);
      return (len >= MIN_LEN) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_shiftreg.sv
// seq_shiftreg
//   History shift register plus fill counter for prog_seqdet.
//   New bits enter at bit 0 and older bits move up one position. The fill
//   counter counts received bits and saturates at the active length.
//   The next-state values are exported so the parent can evaluate a match
//   on the same edge that shifts the bit in.
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   clr       : clear history and fill counter (has priority over shift)
//   shift     : accept din this cycle
//   fill_clr  : with shift, zero the fill counter instead of advancing it
//   din       : serial bit
//   len       : active pattern length (saturation point of the counter)
//   hist_nxt  : history value after shifting din in
//   fill_nxt  : fill counter value after accepting din
module seq_shiftreg #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               fill_clr,
   input  logic               din,
   input  logic [LEN_W-1:0]   len,
   output logic [MAX_LEN-1:0] hist_nxt,
   output logic [LEN_W-1:0]   fill_nxt
);

   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;

   assign hist_nxt = {hist[MAX_LEN-2:0], din};
   assign fill_nxt = (fill >= len) ? len : fill + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_nxt;
         // A non-overlapping match restarts counting so none of the
         // matched bits can complete the next pattern.
         fill <= fill_clr ? '0 : fill_nxt;
      end
   end

endmodule

// File: rtl/prog_seqdet.sv
// prog_seqdet
//   Programmable serial sequence detector. A pattern of 2..MAX_LEN bits is
//   loaded together with an overlap mode; serial bits are then compared
//   against the pattern and every match produces a one-cycle pulse on z
//   one clock after the completing bit, and bumps a saturating counter.
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous reset, active low
//   cfg_load    : load pattern/length/mode this cycle (beats x_valid)
//   cfg_pattern : pattern, bit 0 = most recently received bit
//   cfg_len     : pattern length in bits
//   cfg_overlap : 1 = matches may share bits, 0 = disjoint matches
//   x_valid     : x holds a serial bit this cycle
//   x           : serial bit
//   z           : match pulse
//   match_cnt   : saturating match count (survives reloads)
//   cfg_err     : sticky, last load had an illegal length
//   state       : current FSM state
module prog_seqdet
   import prog_seqdet_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         x_valid,
   input  logic                         x,
   output logic                         z,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         cfg_err,
   output logic [1:0]                   state
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_t             cur, nxt;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;

   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill_nxt;
   logic               load_ok;
   logic               shift_en;
   logic               sr_clr;
   logic               fill_clr;
   logic               hit;

   assign load_ok = len_legal(int'(cfg_len), MAX_LEN);
   assign state   = cur;

   // Only the low len_q bits take part in the compare.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         len_mask[i] = (i < int'(len_q));
   end

   seq_shiftreg #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_sr (
      .clk      (clk),
      .rst      (rst),
      .clr      (sr_clr),
      .shift    (shift_en),
      .fill_clr (fill_clr),
      .din      (x),
      .len      (len_q),
      .hist_nxt (hist_nxt),
      .fill_nxt (fill_nxt)
   );

   // Next state, shift control and match decode.
   always_comb begin
      nxt      = cur;
      shift_en = 1'b0;
      sr_clr   = 1'b0;
      fill_clr = 1'b0;
      hit      = 1'b0;
      if (cfg_load) begin
         // Any load, legal or not, discards the history; a bit arriving
         // in the same cycle is dropped.
         sr_clr = 1'b1;
         nxt    = load_ok ? FILL : UNCFG;
      end else if (x_valid && (cur != UNCFG)) begin
         shift_en = 1'b1;
         hit      = (fill_nxt == len_q) &&
                    (((hist_nxt ^ pat_q) & len_mask) == '0);
         if (hit && !ovl_q) begin
            fill_clr = 1'b1;
            nxt      = FILL;
         end else if (fill_nxt == len_q) begin
            nxt = DETECT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur <= UNCFG;
      else      cur <= nxt;
   end

   // Configuration registers; an illegal load keeps the old values but
   // parks the FSM in UNCFG so they are never used.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         cfg_err <= !load_ok;
         if (load_ok) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
         end
      end
   end

   // Match pulse and saturating counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z         <= 1'b0;
         match_cnt <= '0;
      end else begin
         z <= hit;
         if (hit && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_seqdet.sv
// tb_prog_seqdet
//   Self-checking bench for prog_seqdet. A second instance with CNT_W=2
//   shares all inputs to observe counter saturation. Each serial cycle
//   pushes its expected z into a queue; the test popping it compares the
//   registered z one clock later.
module tb_prog_seqdet;

   localparam int ML = 8;
   localparam int LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_load = 1'b0;
   logic [ML-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic          x_valid = 1'b0;
   logic          x = 1'b0;

   logic          z, z2;
   logic [7:0]    match_cnt;
   logic [1:0]    match_cnt2;
   logic          cfg_err, cfg_err2;
   logic [1:0]    state, state2;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;
   int exp_cnt2 = 0;
   bit exp_q[$];

   prog_seqdet #(.MAX_LEN(ML), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
      .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err), .state(state)
   );

   prog_seqdet #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
      .z(z2), .match_cnt(match_cnt2), .cfg_err(cfg_err2), .state(state2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [ML-1:0] pat, input logic [LW-1:0] len,
                           input logic ov, input logic xv, input logic xb);
      cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      x_valid = xv; x = xb;
      step();
      cfg_load = 1'b0; x_valid = 1'b0; x = 1'b0;
   endtask

   // Drive one serial cycle and record the z it should produce.
   task automatic drive_cycle(input logic v, input logic b, input bit e);
      exp_q.push_back(e);
      x_valid = v; x = b;
      step();
      x_valid = 1'b0; x = 1'b0;
   endtask

   function automatic void bump();
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
      checks++; if (z !== 1'b0) begin failures++; $display("FAIL rst_z got=%b exp=0", z); end
      checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", match_cnt); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
      step();
      rst = 1'b1;
      step();
      // unconfigured: input must be ignored
      for (int i = 0; i < 4; i++) begin
         bit e;
         drive_cycle(1'b1, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL uncfg_z[%0d] got=%b exp=%b", i, z, e); end
      end
   endtask

   task automatic test_overlap();
      bit stim[5] = '{1, 0, 1, 0, 1};
      bit ez[5]   = '{0, 0, 1, 0, 1};
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL ovl_fill_state got=%0d exp=1", state); end
      for (int i = 0; i < 5; i++) begin
         bit e;
         drive_cycle(1'b1, stim[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL ovl_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) bump();
      end
      checks++; if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL ovl_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL ovl_state got=%0d exp=2", state); end
   endtask

   task automatic test_nonoverlap();
      bit stim[5] = '{1, 0, 1, 0, 1};
      bit ez[5]   = '{0, 0, 1, 0, 0};
      load_cfg(8'hA5, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bit e;
         drive_cycle(1'b1, stim[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL novl_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) bump();
      end
      checks++; if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL novl_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL novl_state got=%0d exp=1", state); end
   endtask

   // Pattern 0110 (upper cfg_pattern bits set to junk), bits gapped.
   task automatic test_gapped();
      bit v[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
      bit b[8]  = '{0, 1, 1, 0, 1, 1, 0, 1};
      bit ez[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      load_cfg(8'hF6, 4'd4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bit e;
         drive_cycle(v[i], b[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL gap_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) bump();
      end
      checks++; if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL gap_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
   endtask

   task automatic test_illegal();
      logic [LW-1:0] bad[2] = '{4'd0, 4'd9};
      for (int k = 0; k < 2; k++) begin
         load_cfg(8'hA5, bad[k], 1'b1, 1'b0, 1'b0);
         checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL ill_err[%0d] got=%b exp=1", k, cfg_err); end
         checks++; if (state !== 2'd0) begin failures++; $display("FAIL ill_state[%0d] got=%0d exp=0", k, state); end
         for (int i = 0; i < 4; i++) begin
            bit e;
            drive_cycle(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++; if (z !== e) begin failures++; $display("FAIL ill_z[%0d][%0d] got=%b exp=%b", k, i, z, e); end
         end
      end
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL ill_clr_err got=%b exp=0", cfg_err); end
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL ill_clr_state got=%0d exp=1", state); end
   endtask

   // Load with a concurrent 1 on x: that bit must be dropped.
   task automatic test_load_priority();
      bit stim[4] = '{0, 1, 0, 1};
      bit ez[4]   = '{0, 0, 0, 1};
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         bit e;
         drive_cycle(1'b1, stim[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL prio_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) bump();
      end
   endtask

   task automatic test_reset_mid();
      bit stim[6] = '{1, 0, 1, 1, 0, 1};
      bit ez[6]   = '{0, 0, 0, 0, 0, 1};
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         bit e;
         drive_cycle(1'b1, stim[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL rmid_pre_z[%0d] got=%b exp=%b", i, z, e); end
      end
      rst = 1'b0;
      #2;
      exp_cnt = 0; exp_cnt2 = 0;
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", state); end
      checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", match_cnt); end
      step();
      rst = 1'b1;
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i < 6; i++) begin
         bit e;
         drive_cycle(1'b1, stim[i], ez[i]);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL rmid_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) bump();
      end
   endtask

   // Five overlapping matches of 101 in 10101010101.
   task automatic test_saturate();
      int n = 0;
      load_cfg(8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         bit e;
         bit ev = (i >= 2) && (i % 2 == 0);
         drive_cycle(1'b1, (i % 2 == 0), ev);
         e = exp_q.pop_front();
         checks++; if (z !== e) begin failures++; $display("FAIL sat_z[%0d] got=%b exp=%b", i, z, e); end
         if (e) begin bump(); n++; end
      end
      checks++; if (n !== 5) begin failures++; $display("FAIL sat_nmatch got=%0d exp=5", n); end
      checks++; if (match_cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", match_cnt2); end
      checks++; if (match_cnt2 !== 2'(exp_cnt2)) begin failures++; $display("FAIL sat_cnt2_model got=%0d exp=%0d", match_cnt2, exp_cnt2); end
      checks++; if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
      // a reload leaves the count alone
      load_cfg(8'h06, 4'd4, 1'b0, 1'b0, 1'b0);
      checks++; if (match_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL load_keeps_cnt got=%0d exp=%0d", match_cnt, exp_cnt); end
   endtask

   initial begin
      #3;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gapped();
      test_illegal();
      test_load_priority();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
